// File: rtl/vga_timing_gen_if.sv
// VGA raster timing bundle.
// master: the timing generator (consumes pix_en/restart, drives timing outputs).
// slave : the display pipeline / pads (drives pix_en/restart, consumes timing).
//   pix_en  - pixel-slot enable, raster advances only when 1
//   restart - synchronous raster restart, wins over pix_en
//   hs, vs  - sync outputs at configured polarity
//   active  - current slot is visible
//   vblank  - current line is at or beyond the visible line count
//   x, y    - pixel coordinates while active, else 0
//   sof/sol - one-clk strobes for start of frame / start of visible line
interface vga_timing_if #(
    parameter int CW = 11
);
    logic          pix_en;
    logic          restart;
    logic          hs;
    logic          vs;
    logic          active;
    logic          vblank;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          sof;
    logic          sol;

    modport master (
        input  pix_en, restart,
        output hs, vs, active, vblank, x, y, sof, sol
    );

    modport slave (
        output pix_en, restart,
        input  hs, vs, active, vblank, x, y, sof, sol
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator.
// Counters h/v name the next slot to present; every enabled edge registers the
// decoded outputs for (h,v) and then advances the raster by one slot.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   vif  - vga_timing_if.master (pix_en/restart in; hs, vs, active, vblank,
//          x, y, sof, sol out, all registered)
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CW       = 11
) (
    input  logic         clk,
    input  logic         rst,
    vga_timing_if.master vif
);
    localparam int LINE  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int FRAME = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST = CW'(LINE - 1);
    localparam logic [CW-1:0] V_LAST = CW'(FRAME - 1);
    localparam logic [CW-1:0] H_VIS  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] h, v;
    logic [CW-1:0] h_nxt, v_nxt;

    logic          hs_q, vs_q, act_q, vbl_q, sof_q, sol_q;
    logic [CW-1:0] x_q, y_q;

    // Decode of the slot held in the counters (registered below, never
    // routed straight to the ports).
    logic slot_act, slot_hs, slot_vs, slot_vbl, slot_sof, slot_sol;

    always_comb begin
        slot_vbl = (v >= V_VIS);
        slot_act = (h < H_VIS) && !slot_vbl;
        slot_hs  = (h >= HS_BEG) && (h < HS_END);
        // v only changes on the wrap to h=0, so vs edges line up with h=0.
        slot_vs  = (v >= VS_BEG) && (v < VS_END);
        slot_sof = (h == '0) && (v == '0);
        slot_sol = (h == '0) && !slot_vbl;
    end

    always_comb begin
        h_nxt = h + 1'b1;
        v_nxt = v;
        if (h == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v == V_LAST) ? '0 : v + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h     <= '0;
            v     <= '0;
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            act_q <= 1'b0;
            vbl_q <= 1'b0;
            x_q   <= '0;
            y_q   <= '0;
            sof_q <= 1'b0;
            sol_q <= 1'b0;
        end else if (vif.restart) begin
            h     <= '0;
            v     <= '0;
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            act_q <= 1'b0;
            vbl_q <= 1'b0;
            x_q   <= '0;
            y_q   <= '0;
            sof_q <= 1'b0;
            sol_q <= 1'b0;
        end else if (vif.pix_en) begin
            h     <= h_nxt;
            v     <= v_nxt;
            hs_q  <= slot_hs ? HS_POL : ~HS_POL;
            vs_q  <= slot_vs ? VS_POL : ~VS_POL;
            act_q <= slot_act;
            vbl_q <= slot_vbl;
            x_q   <= slot_act ? h : '0;
            y_q   <= slot_act ? v : '0;
            sof_q <= slot_sof;
            sol_q <= slot_sol;
        end else begin
            // Raster holds; strobes are one system clock wide regardless.
            sof_q <= 1'b0;
            sol_q <= 1'b0;
        end
    end

    assign vif.hs     = hs_q;
    assign vif.vs     = vs_q;
    assign vif.active = act_q;
    assign vif.vblank = vbl_q;
    assign vif.x      = x_q;
    assign vif.y      = y_q;
    assign vif.sof    = sof_q;
    assign vif.sol    = sol_q;
endmodule
